// File: rtl/ifft_arbiter.sv
// ifft_arbiter: round-robin owner selection for a single shared ifft_core.
// One job at a time runs GRANT -> START -> WAIT -> DONE. The WAIT state is
// bounded by a cycle counter so that a core which never answers cannot hang
// the requesters. Every output comes straight from a flop.
module ifft_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] sel,
    output logic                       start_ifft,
    input  logic                       ifft_done,
    output logic [NUM_REQ-1:0]         done,
    output logic                       timeout_err,
    output logic                       busy,
    output logic [15:0]                job_count
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    // The abort fires on the edge where the counter would reach TIMEOUT-1.
    // WAIT starts one cycle after START, so DONE then lands exactly TIMEOUT
    // cycles after the start pulse.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       ptr_q, ptr_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                start_q, start_d;
    logic                to_q, to_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [15:0]         job_cnt_q;
    logic                job_inc;

    logic                win_found;
    logic [SW-1:0]       win_idx;
    logic [SW-1:0]       ptr_next;

    // Round-robin search: walk from ptr upward with wrap; the first set req wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = SW'(j);
            end
        end
    end

    // The pointer moves just past the owner that is finishing.
    always_comb begin
        ptr_next = (int'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
    end

    // Next-state and next-output logic. Owner state (grant/sel) only changes
    // when leaving IDLE and when leaving DONE, so it is frozen for the job.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        done_d  = '0;
        to_d    = 1'b0;
        job_inc = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    sel_d   = win_idx;
                    grant_d = NUM_REQ'(1) << win_idx;
                end
            end
            GRANT: begin
                // One cycle for the frame mux to settle before the core starts.
                state_d = START;
                start_d = 1'b1;
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the abort cycle still counts as a clean finish.
                if (ifft_done) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    job_inc = 1'b1;
                    ptr_d   = ptr_next;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    to_d    = 1'b1;
                    job_inc = 1'b1;
                    ptr_d   = ptr_next;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            done_q  <= '0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            done_q  <= done_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
        end
    end

    // Completed-job counter, timed-out jobs included; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_cnt_q <= '0;
        end else if (job_inc) begin
            job_cnt_q <= job_cnt_q + 16'd1;
        end
    end

    assign grant       = grant_q;
    assign sel         = sel_q;
    assign start_ifft  = start_q;
    assign done        = done_q;
    assign timeout_err = to_q;
    assign busy        = busy_q;
    assign job_count   = job_cnt_q;

endmodule

// File: tb/tb_ifft_arbiter.sv
// Bench for ifft_arbiter: a table of jobs plus hand-written reset, stray-pulse
// and wrap sequences. Expected done events go into a queue when a job starts
// and are popped by a monitor whenever the DUT pulses done.
module tb_ifft_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic           ifft_done = 1'b0;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [1:0]     sel;
    logic           start_ifft;
    logic           timeout_err;
    logic           busy;
    logic [15:0]    job_count;

    ifft_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .sel         (sel),
        .start_ifft  (start_ifft),
        .ifft_done   (ifft_done),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy),
        .job_count   (job_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] done;
        logic         to;
        logic [15:0]  cnt;
    } exp_t;

    typedef struct {
        logic [N-1:0] req;    // request pattern presented before the job
        int           dly;    // negedges after start before ifft_done; -1 = never
        logic [N-1:0] g;      // expected grant
        logic [1:0]   s;      // expected sel
        logic         to;     // expected timeout_err
        logic [N-1:0] mid;    // req pattern applied once the job has started
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [15:0] model_cnt = '0;
    vec_t        vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done/timeout_err pulse must match a queued job.
    always @(negedge clk) begin
        if (reset_n && (done != '0 || timeout_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {27'd0, timeout_err, done}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_vec", done, mon_e.done);
                chk("timeout_err", timeout_err, mon_e.to);
                chk("job_count", job_count, mon_e.cnt);
            end
        end
    end

    // Run one job; called at a negedge, returns at the negedge where done is seen.
    task automatic run_job(input vec_t v);
        int n;
        int exp_lat;
        logic was_busy;
        was_busy = busy;
        req = v.req;
        n = 0;
        while (!start_ifft && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("start_lat", n, was_busy ? 3 : 2);
        chk("grant", grant, v.g);
        chk("sel", sel, v.s);
        chk("busy_job", busy, 1);
        model_cnt = model_cnt + 16'd1;
        sb.push_back('{v.g, v.to, model_cnt});
        req = v.mid;
        n = 0;
        while (done == '0 && n < 100) begin
            @(negedge clk);
            n++;
            ifft_done = (n == v.dly);
        end
        ifft_done = 1'b0;
        exp_lat = (v.dly >= 1 && v.dly <= TO - 1) ? v.dly + 1 : TO;
        chk("done_lat", n, exp_lat);
        chk("grant_frozen", grant, v.g);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        vt[0] = '{4'b0001, 10, 4'b0001, 2'd0, 1'b0, 4'b0000};
        vt[1] = '{4'b1111,  5, 4'b0010, 2'd1, 1'b0, 4'b1111};
        vt[2] = '{4'b1111,  1, 4'b0100, 2'd2, 1'b0, 4'b1111};
        vt[3] = '{4'b1111, 20, 4'b1000, 2'd3, 1'b0, 4'b1111};
        vt[4] = '{4'b1111,  3, 4'b0001, 2'd0, 1'b0, 4'b1111};
        vt[5] = '{4'b0001, -1, 4'b0001, 2'd0, 1'b1, 4'b0000};
        vt[6] = '{4'b0101, 63, 4'b0100, 2'd2, 1'b0, 4'b1010};
        vt[7] = '{4'b0011, 62, 4'b0001, 2'd0, 1'b0, 4'b0000};
        vt[8] = '{4'b1001,  4, 4'b1000, 2'd3, 1'b0, 4'b0110};

        // Asynchronous reset: outputs are zero before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_outs", {grant, sel, start_ifft, done, timeout_err, busy}, 32'd0);
        chk("rst_count", job_count, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Table of jobs: round-robin, timeout, tie, owner drop, mid-job req change.
        for (int i = 0; i < 9; i++) begin
            run_job(vt[i]);
        end
        req = '0;

        // Stray ifft_done in IDLE is ignored.
        repeat (2) @(negedge clk);
        ifft_done = 1'b1;
        @(negedge clk);
        ifft_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", busy, 32'd0);
        chk("stray_count", job_count, model_cnt);

        // Move the pointer to 2, then abandon a job with reset in WAIT.
        run_job('{4'b0010, 2, 4'b0010, 2'd1, 1'b0, 4'b0000});
        req = 4'b0100;
        n = 0;
        while (!start_ifft && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abandon_start", start_ifft, 32'd1);
        chk("abandon_grant", grant, 32'b0100);
        req = '0;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_outs", {grant, sel, start_ifft, done, timeout_err, busy}, 32'd0);
        chk("midrst_count", job_count, 32'd0);
        model_cnt = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        ifft_done = 1'b1;
        @(negedge clk);
        ifft_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("postrst_busy", busy, 32'd0);
        // Pointer is back at 0 after reset.
        run_job('{4'b1111, 4, 4'b0001, 2'd0, 1'b0, 4'b0000});

        // Counter wrap: preload 0xFFFF, then one more job.
        @(negedge clk);
        force dut.job_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.job_cnt_q;
        @(negedge clk);
        chk("preload", job_count, 32'hFFFF);
        model_cnt = 16'hFFFF;
        run_job('{4'b0010, 6, 4'b0010, 2'd1, 1'b0, 4'b0000});
        chk("wrap", job_count, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        chk("end_idle", busy, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifft_arbiter.md
IFFT_ARBITER -- requirements
Module: ifft_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ifft_core (2..8).
REQ-002 Parameter TIMEOUT, default 64: maximum cycles from start_ifft to ifft_done before abort.
REQ-003 Port clk  input  1  single clock; all logic is rising-edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  NUM_REQ  per-requester job request level.
REQ-006 Port grant  output  NUM_REQ  one-hot owner of the core; zero when idle.
REQ-007 Port sel  output  $clog2(NUM_REQ)  index of the current owner; drives the frame input mux ahead of the core.
REQ-008 Port start_ifft  output  1  one-cycle start pulse to the core.
REQ-009 Port ifft_done  input  1  one-cycle completion pulse from the core.
REQ-010 Port done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 Port timeout_err  output  1  one-cycle pulse, coincident with done, when a job aborted on timeout.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port job_count  output  16  count of completed jobs, including timed-out jobs; wraps 0xFFFF->0.

Function
REQ-014 FSM states: IDLE, GRANT, START, WAIT, DONE; all outputs registered.
REQ-015 IDLE, req != 0 -> GRANT next cycle; grant/sel take the winner's value on that same edge.
REQ-016 Arbitration: round-robin. Search starts at pointer ptr and wraps through NUM_REQ-1 to 0; the first set req bit wins.
REQ-017 ptr resets to 0 and is set to (owner+1) mod NUM_REQ on entry to DONE.
REQ-018 GRANT lasts exactly 1 cycle (mux settle) -> START.
REQ-019 START lasts exactly 1 cycle with start_ifft=1 -> WAIT; start_ifft is 0 in all other states.
REQ-020 WAIT: a cycle counter clears on entry and increments every cycle.
REQ-021 WAIT: ifft_done=1 -> DONE with timeout_err=0.
REQ-022 WAIT: counter reaching TIMEOUT-1 without ifft_done -> DONE with timeout_err=1.
REQ-023 WAIT: if ifft_done and the timeout condition occur in the same cycle, ifft_done wins (timeout_err=0).
REQ-024 DONE lasts 1 cycle: done[owner]=1, timeout_err per REQ-021..023, job_count increments, then -> IDLE.
REQ-025 grant and sel clear on the DONE->IDLE edge; minimum spacing between two start_ifft pulses is 5 cycles.
REQ-026 grant, sel and owner are frozen from GRANT through DONE; req changes during that window do not affect them.
REQ-027 The owner dropping req mid-job does not abort the job; done is still pulsed to that owner.
REQ-028 ifft_done received in IDLE, GRANT, START or DONE is ignored and causes no output change.
REQ-029 A requester still holding req after its done is re-eligible from IDLE under REQ-016; it is not guaranteed back-to-back service.
REQ-030 Latency: req asserted in IDLE to start_ifft = 2 cycles; ifft_done to done = 1 cycle.

Reset
REQ-031 reset_n=0 immediately, without waiting for a clock edge, forces:
- state=IDLE, ptr=0, counter=0, job_count=0
- grant=0, sel=0, start_ifft=0, done=0, timeout_err=0, busy=0
REQ-032 Reset asserted mid-job abandons the job; no done pulse is issued for it.
REQ-033 After reset_n deasserts, the first req is sampled on the first rising edge.

Verification
REQ-034 Single job: req=0001 from IDLE; ifft_done returned 10 cycles after start_ifft -> grant=0001 and sel=0; start_ifft 2 cycles after req; done=0001 one cycle after ifft_done; job_count=1.
REQ-035 Round-robin: req=1111 held for 4 jobs -> grant order 0001, 0010, 0100, 1000; then 0001 again.
REQ-036 Timeout: grant with ifft_done never asserted, TIMEOUT=64 -> done and timeout_err pulse together 64 cycles after start_ifft; FSM returns to IDLE.
REQ-037 Tie and stray pulse:
- ifft_done arriving in the exact timeout cycle -> timeout_err=0.
- ifft_done pulsed in IDLE -> no done, no count change.
REQ-038 Reset mid-WAIT: reset_n pulsed low -> all outputs 0 immediately without a clock edge; no done pulse; job_count=0; the next req is served starting from requester 0.
REQ-039 Wrap: job_count preloaded to 0xFFFF via a forced sequence, one more job completed -> job_count=0x0000.
